pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter unit for the multicycle CPU; owns the PC register.
- Computes PC+4, branch targets and jump targets internally, so the address generator no longer supplies them.
- Adds a write-enable for multicycle state control, six branch conditions, jump-register, and a misaligned-target trap with EPC capture and exception return (eret).

Parameters:
- WIDTH, 32, PC/address width in bits; must be ≥ 32.
- RESET_VECTOR, 32'h0000_0000, PC value on reset; must be word-aligned.
- TRAP_VECTOR, 32'h0000_0080, PC value loaded on a misaligned-target trap; must be word-aligned.

Ports:
- clk  input  1  system clock, all state updates on the posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- pcWrite  input  1  PC update enable from the control FSM; when 0, all state holds.
- branchOp  input  3  branch type: 000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 none.
- zero  input  1  ALU zero flag.
- negative  input  1  ALU result sign flag.
- branchOffset  input  16  instruction immediate, in words.
- jump  input  1  j/jal target select.
- jumpIndex  input  26  instruction index field.
- jumpReg  input  1  jr/jalr target select.
- regAddr  input  WIDTH  jump-register target.
- eret  input  1  exception return.
- PC  output  WIDTH  current PC (registered).
- PC4  output  WIDTH  PC+4, combinational.
- epc  output  WIDTH  exception PC (registered).
- trap  output  1  registered one-cycle pulse, high in the cycle after a trap is taken.
- inTrap  output  1  high from trap entry until eret.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_VECTOR, epc=RESET_VECTOR, trap=0, inTrap=0.
  - The first posedge after release evaluates normally.
- Target arithmetic (all modulo 2^WIDTH, wrap-around silent, no overflow flag):
  - PC4 = PC+4.
  - branchTarget = PC4 + (sign-extend(branchOffset) << 2).
  - jumpTarget = {PC4[WIDTH-1:28], jumpIndex, 2'b00}.
- Branch taken conditions:
  - beq: zero.
  - bne: !zero.
  - blez: zero || negative.
  - bgtz: !zero && !negative.
  - bltz: negative.
  - bgez: !negative.
  - none / 111: never taken.
- Next-PC priority at each posedge with pcWrite=1, highest first:
  1. Misaligned jr: jumpReg=1 and regAddr[1:0]≠0.
     - PC<=TRAP_VECTOR, trap<=1, inTrap<=1.
     - epc<=PC only if inTrap was 0. Double fault leaves epc unchanged.
  2. eret=1: PC<=epc, inTrap<=0.
  3. jumpReg=1 (aligned): PC<=regAddr.
  4. jump=1: PC<=jumpTarget.
  5. Branch taken: PC<=branchTarget.
  6. Otherwise: PC<=PC4.
- trap is 0 in every cycle not immediately following a trap entry, including pcWrite=0 cycles.
- Simultaneous requests resolve strictly by the priority order above (e.g. jump+taken branch -> jumpTarget; eret+jumpReg aligned -> epc).
- pcWrite=0: PC, epc and inTrap hold; trap<=0; jumpReg misalignment is ignored (no trap).
- eret while inTrap=0: still loads PC<=epc (RESET_VECTOR after reset); inTrap stays 0.
- Reset asserted mid-operation: takes effect immediately regardless of clk; a pending trap pulse is cleared.
- Latency: one cycle from control inputs to PC. PC4 follows PC combinationally.

Test Plan:
1. Hold reset=0, then release with pcWrite=1 and no controls for 3 clocks -> PC=0x0, 0x4, 0x8, 0xC; epc=0, trap=0.
2. PC=0x100, branchOp=001, zero=1, branchOffset=16'hFFFE -> PC=0xFC. Same stimulus with zero=0 -> PC=0x104. bgtz with negative=1 -> PC=0x104.
3. PC=0x8000_0010, jump=1, jumpIndex=26'h0000040, branchOp=001, zero=1 -> PC=0x8000_0100 (jump beats branch).
4. PC=0x200, jumpReg=1, regAddr=0x301:
   - Response: PC=0x80, epc=0x200, trap=1 for exactly one cycle, inTrap=1.
   - Then eret=1 -> PC=0x200, inTrap=0.
5. While inTrap=1 with PC=0x80, a second jumpReg to 0x3 -> PC=0x80, epc stays 0x200, trap pulses again.
6. Alternate pcWrite=0/1 with jump=1, and assert reset asynchronously between clock edges:
   - PC changes only on pcWrite=1 edges.
   - PC drops to 0 immediately on reset assertion, without waiting for a clock edge.
   - PC=0xFFFF_FFFC with PC+4 path -> PC=0x0 (wrap).

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter unit for the multicycle CPU.
// Owns the PC register and forms PC+4, branch and jump targets internally.
// Supports six branch conditions, j/jal, jr/jalr, and a misaligned-jr trap
// with EPC capture and exception return.
//
// Ports:
//   clk          system clock, state updates on posedge
//   reset        asynchronous active-low reset
//   pcWrite      PC update enable; when 0 all state holds and trap clears
//   branchOp     000 none, 001 beq, 010 bne, 011 blez, 100 bgtz,
//                101 bltz, 110 bgez, 111 none
//   zero         ALU zero flag
//   negative     ALU result sign flag
//   branchOffset branch immediate, in words
//   jump         j/jal target select
//   jumpIndex    instruction index field
//   jumpReg      jr/jalr target select
//   regAddr      jump-register target
//   eret         exception return
//   PC           current PC (registered)
//   PC4          PC+4 (combinational)
//   epc          exception PC (registered)
//   trap         one-cycle pulse in the cycle after a trap is taken
//   inTrap       high from trap entry until eret
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0080
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pcWrite,
    input  logic [2:0]       branchOp,
    input  logic             zero,
    input  logic             negative,
    input  logic [15:0]      branchOffset,
    input  logic             jump,
    input  logic [25:0]      jumpIndex,
    input  logic             jumpReg,
    input  logic [WIDTH-1:0] regAddr,
    input  logic             eret,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC4,
    output logic [WIDTH-1:0] epc,
    output logic             trap,
    output logic             inTrap
);

    logic [WIDTH-1:0] branch_disp;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic             branch_taken;
    logic             misaligned_jr;
    logic [WIDTH-1:0] next_pc;

    assign PC4 = PC + {{(WIDTH-3){1'b0}}, 3'b100};

    // Offset is in words: sign-extend and scale by 4.
    assign branch_disp   = {{(WIDTH-18){branchOffset[15]}}, branchOffset, 2'b00};
    assign branch_target = PC4 + branch_disp;
    assign jump_target   = {PC4[WIDTH-1:28], jumpIndex, 2'b00};

    assign misaligned_jr = jumpReg && (regAddr[1:0] != 2'b00);

    always_comb begin
        branch_taken = 1'b0;
        case (branchOp)
            3'b001:  branch_taken = zero;
            3'b010:  branch_taken = !zero;
            3'b011:  branch_taken = zero || negative;
            3'b100:  branch_taken = !zero && !negative;
            3'b101:  branch_taken = negative;
            3'b110:  branch_taken = !negative;
            default: branch_taken = 1'b0;
        endcase
    end

    // Non-trap next-PC selection; the misaligned-jr trap overrides this below.
    always_comb begin
        next_pc = PC4;
        if (eret)              next_pc = epc;
        else if (jumpReg)      next_pc = regAddr;
        else if (jump)         next_pc = jump_target;
        else if (branch_taken) next_pc = branch_target;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC     <= RESET_VECTOR;
            epc    <= RESET_VECTOR;
            trap   <= 1'b0;
            inTrap <= 1'b0;
        end else begin
            trap <= 1'b0;
            if (pcWrite) begin
                if (misaligned_jr) begin
                    PC     <= TRAP_VECTOR;
                    trap   <= 1'b1;
                    inTrap <= 1'b1;
                    // A fault taken while already in the handler keeps the original EPC.
                    if (!inTrap) epc <= PC;
                end else begin
                    PC <= next_pc;
                    if (eret) inTrap <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        pcWrite;
    logic [2:0]  branchOp;
    logic        zero;
    logic        negative;
    logic [15:0] branchOffset;
    logic        jump;
    logic [25:0] jumpIndex;
    logic        jumpReg;
    logic [31:0] regAddr;
    logic        eret;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic [31:0] epc;
    logic        trap;
    logic        inTrap;

    int unsigned passed;
    int unsigned total;

    pc_sequencer #(
        .WIDTH(32),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR(32'h0000_0080)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pcWrite(pcWrite),
        .branchOp(branchOp),
        .zero(zero),
        .negative(negative),
        .branchOffset(branchOffset),
        .jump(jump),
        .jumpIndex(jumpIndex),
        .jumpReg(jumpReg),
        .regAddr(regAddr),
        .eret(eret),
        .PC(PC),
        .PC4(PC4),
        .epc(epc),
        .trap(trap),
        .inTrap(inTrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required $finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic clear_ctrl();
        pcWrite      = 1'b1;
        branchOp     = 3'b000;
        zero         = 1'b0;
        negative     = 1'b0;
        branchOffset = 16'h0000;
        jump         = 1'b0;
        jumpIndex    = 26'h0;
        jumpReg      = 1'b0;
        regAddr      = 32'h0;
        eret         = 1'b0;
    endtask

    // Advance one active edge and settle outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load the PC through an aligned jump-register.
    task automatic set_pc(input logic [31:0] addr);
        clear_ctrl();
        jumpReg = 1'b1;
        regAddr = addr;
        tick();
        clear_ctrl();
    endtask

    task automatic test_reset();
        clear_ctrl();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (PC !== 32'h0) $display("FAIL reset_pc: got %h want %h", PC, 32'h0); else passed++;
        total++; if (epc !== 32'h0) $display("FAIL reset_epc: got %h want %h", epc, 32'h0); else passed++;
        total++; if (trap !== 1'b0) $display("FAIL reset_trap: got %b want 0", trap); else passed++;
        total++; if (inTrap !== 1'b0) $display("FAIL reset_intrap: got %b want 0", inTrap); else passed++;
        total++; if (PC4 !== 32'h4) $display("FAIL reset_pc4: got %h want %h", PC4, 32'h4); else passed++;
        reset = 1'b1;
        tick();
        total++; if (PC !== 32'h4) $display("FAIL seq_pc1: got %h want %h", PC, 32'h4); else passed++;
        tick();
        total++; if (PC !== 32'h8) $display("FAIL seq_pc2: got %h want %h", PC, 32'h8); else passed++;
        tick();
        total++; if (PC !== 32'hC) $display("FAIL seq_pc3: got %h want %h", PC, 32'hC); else passed++;
        total++; if (trap !== 1'b0 || epc !== 32'h0) $display("FAIL seq_trap_epc: got trap=%b epc=%h want trap=0 epc=0", trap, epc); else passed++;
    endtask

    task automatic test_branch();
        set_pc(32'h100);
        branchOp = 3'b001; zero = 1'b1; branchOffset = 16'hFFFE;
        tick();
        total++; if (PC !== 32'hFC) $display("FAIL beq_taken: got %h want %h", PC, 32'hFC); else passed++;

        set_pc(32'h100);
        branchOp = 3'b001; zero = 1'b0; branchOffset = 16'hFFFE;
        tick();
        total++; if (PC !== 32'h104) $display("FAIL beq_not_taken: got %h want %h", PC, 32'h104); else passed++;

        set_pc(32'h100);
        branchOp = 3'b100; zero = 1'b0; negative = 1'b1; branchOffset = 16'hFFFE;
        tick();
        total++; if (PC !== 32'h104) $display("FAIL bgtz_neg: got %h want %h", PC, 32'h104); else passed++;

        set_pc(32'h100);
        branchOp = 3'b101; negative = 1'b1; branchOffset = 16'h0010;
        tick();
        total++; if (PC !== 32'h144) $display("FAIL bltz_taken: got %h want %h", PC, 32'h144); else passed++;

        set_pc(32'h100);
        branchOp = 3'b010; zero = 1'b0; branchOffset = 16'h0003;
        tick();
        total++; if (PC !== 32'h110) $display("FAIL bne_taken: got %h want %h", PC, 32'h110); else passed++;

        set_pc(32'h100);
        branchOp = 3'b011; zero = 1'b0; negative = 1'b0; branchOffset = 16'h0003;
        tick();
        total++; if (PC !== 32'h104) $display("FAIL blez_pos: got %h want %h", PC, 32'h104); else passed++;

        set_pc(32'h100);
        branchOp = 3'b110; negative = 1'b0; branchOffset = 16'h0001;
        tick();
        total++; if (PC !== 32'h108) $display("FAIL bgez_taken: got %h want %h", PC, 32'h108); else passed++;

        set_pc(32'h100);
        branchOp = 3'b111; zero = 1'b1; negative = 1'b1; branchOffset = 16'h0010;
        tick();
        total++; if (PC !== 32'h104) $display("FAIL op111_never: got %h want %h", PC, 32'h104); else passed++;
        clear_ctrl();
    endtask

    task automatic test_jump_priority();
        set_pc(32'h8000_0010);
        jump = 1'b1; jumpIndex = 26'h0000040; branchOp = 3'b001; zero = 1'b1;
        tick();
        total++; if (PC !== 32'h8000_0100) $display("FAIL jump_over_branch: got %h want %h", PC, 32'h8000_0100); else passed++;
        clear_ctrl();
    endtask

    task automatic test_trap();
        set_pc(32'h200);
        jumpReg = 1'b1; regAddr = 32'h301; jump = 1'b1; jumpIndex = 26'h1;
        tick();
        total++; if (PC !== 32'h80) $display("FAIL trap_pc: got %h want %h", PC, 32'h80); else passed++;
        total++; if (epc !== 32'h200) $display("FAIL trap_epc: got %h want %h", epc, 32'h200); else passed++;
        total++; if (trap !== 1'b1) $display("FAIL trap_pulse: got %b want 1", trap); else passed++;
        total++; if (inTrap !== 1'b1) $display("FAIL trap_intrap: got %b want 1", inTrap); else passed++;

        // Hold cycle: pulse must drop, state holds, misaligned jr ignored.
        clear_ctrl();
        pcWrite = 1'b0; jumpReg = 1'b1; regAddr = 32'h2;
        tick();
        total++; if (trap !== 1'b0) $display("FAIL trap_one_cycle: got %b want 0", trap); else passed++;
        total++; if (PC !== 32'h80 || inTrap !== 1'b1) $display("FAIL hold_state: got PC=%h inTrap=%b want PC=80 inTrap=1", PC, inTrap); else passed++;

        // Double fault while in the handler.
        clear_ctrl();
        jumpReg = 1'b1; regAddr = 32'h3;
        tick();
        total++; if (PC !== 32'h80) $display("FAIL dfault_pc: got %h want %h", PC, 32'h80); else passed++;
        total++; if (epc !== 32'h200) $display("FAIL dfault_epc: got %h want %h", epc, 32'h200); else passed++;
        total++; if (trap !== 1'b1) $display("FAIL dfault_pulse: got %b want 1", trap); else passed++;

        // eret has priority over aligned jr.
        clear_ctrl();
        eret = 1'b1; jumpReg = 1'b1; regAddr = 32'h400;
        tick();
        total++; if (PC !== 32'h200) $display("FAIL eret_pc: got %h want %h", PC, 32'h200); else passed++;
        total++; if (inTrap !== 1'b0 || trap !== 1'b0) $display("FAIL eret_flags: got inTrap=%b trap=%b want 0 0", inTrap, trap); else passed++;

        // eret outside the handler still returns to epc.
        clear_ctrl();
        set_pc(32'h500);
        eret = 1'b1;
        tick();
        total++; if (PC !== 32'h200 || inTrap !== 1'b0) $display("FAIL eret_idle: got PC=%h inTrap=%b want PC=200 inTrap=0", PC, inTrap); else passed++;
        clear_ctrl();
    endtask

    task automatic test_pcwrite_reset();
        set_pc(32'h200);
        jump = 1'b1; jumpIndex = 26'h10;
        pcWrite = 1'b0;
        tick();
        total++; if (PC !== 32'h200) $display("FAIL pcwrite0_hold: got %h want %h", PC, 32'h200); else passed++;
        pcWrite = 1'b1;
        tick();
        total++; if (PC !== 32'h40) $display("FAIL pcwrite1_jump: got %h want %h", PC, 32'h40); else passed++;
        pcWrite = 1'b0; jumpIndex = 26'h20;
        tick();
        total++; if (PC !== 32'h40) $display("FAIL pcwrite0_hold2: got %h want %h", PC, 32'h40); else passed++;

        // Trap, then reset between edges must clear everything at once.
        clear_ctrl();
        jumpReg = 1'b1; regAddr = 32'h41;
        tick();
        total++; if (trap !== 1'b1 || epc !== 32'h40) $display("FAIL pre_reset_trap: got trap=%b epc=%h want 1 40", trap, epc); else passed++;
        clear_ctrl();
        #1 reset = 1'b0;
        #1;
        total++; if (PC !== 32'h0 || epc !== 32'h0) $display("FAIL async_reset_pc: got PC=%h epc=%h want 0 0", PC, epc); else passed++;
        total++; if (trap !== 1'b0 || inTrap !== 1'b0) $display("FAIL async_reset_flags: got trap=%b inTrap=%b want 0 0", trap, inTrap); else passed++;
        @(negedge clk);
        reset = 1'b1;

        // Wrap-around on the PC+4 path.
        set_pc(32'hFFFF_FFFC);
        total++; if (PC4 !== 32'h0) $display("FAIL wrap_pc4: got %h want %h", PC4, 32'h0); else passed++;
        tick();
        total++; if (PC !== 32'h0) $display("FAIL wrap_pc: got %h want %h", PC, 32'h0); else passed++;
        clear_ctrl();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b0;
        clear_ctrl();
        test_reset();
        test_branch();
        test_jump_priority();
        test_trap();
        test_pcwrite_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
